window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/morph_pkg.sv | 24 ++
 rtl/line_buffer.sv | 25 ++
 rtl/window_3x3_gen.sv | 184 ++++++++++++++++++
 tb/tb_window_3x3_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// Shared types and defaults for the 3x3 window generator and its line buffers.
package morph_pkg;

    localparam int PIX_W          = 4;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
    localparam int DEF_X_W        = $clog2(DEF_IMG_WIDTH);
    localparam int DEF_Y_W        = $clog2(DEF_IMG_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ROWPAD,
        S_FLUSH
    } state_t;

    // One window column: top = row y-2, mid = row y-1, bot = row y of the input stream.
    typedef struct packed {
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] bot;
    } col_t;

endpackage

// File: rtl/line_buffer.sv
// Single-row pixel store: one write and one registered read per cycle.
module line_buffer
    import morph_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster-order 3x3 neighbourhood generator with zero padding at the image borders.
//
// state  | meaning
// IDLE   | waiting for a frame_start transfer; other pixels are dropped
// RUN    | accepting pixels of the current frame
// ROWPAD | one stall cycle shifting a zero column to close the right edge
// FLUSH  | shifting a zero row (W+1 cycles) to emit the last image row
module window_3x3_gen
    import morph_pkg::*;
#(
    parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
    localparam int XW         = $clog2(IMG_WIDTH),
    localparam int YW         = $clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             frame_start,
    output logic             pix_ready,
    output logic [PIX_W-1:0] p00, p01, p02,
    output logic [PIX_W-1:0] p10, p11, p12,
    output logic [PIX_W-1:0] p20, p21, p22,
    output logic             win_valid,
    output logic [XW-1:0]    win_x,
    output logic [YW-1:0]    win_y
);

    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int RW = $clog2(IMG_HEIGHT + 1);
    localparam logic [CW-1:0] X_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] X_PAD   = CW'(IMG_WIDTH);
    localparam logic [RW-1:0] Y_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] Y_FLUSH = RW'(IMG_HEIGHT);

    state_t           state, state_nxt;
    logic [CW-1:0]    cx, cx_nxt, ev_x;
    logic [RW-1:0]    cy, cy_nxt, ev_y;
    logic             ev, out_en, flush_merge, lb_we, xfer;
    col_t             h1, h2, ev_col, lb_col;
    logic [PIX_W-1:0] lb1_q, lb2_q;
    logic [XW-1:0]    rd_addr;

    assign xfer   = pix_valid & pix_ready;
    assign out_en = ev && (ev_x != '0) && (ev_y != '0);

    // Rows above the image read as zero regardless of stale line-buffer data.
    always_comb begin
        lb_col = '0;
        if (cy >= RW'(2)) lb_col.top = lb2_q;
        if (cy != '0)     lb_col.mid = lb1_q;
    end

    always_comb begin
        state_nxt   = state;
        cx_nxt      = cx;
        cy_nxt      = cy;
        ev          = 1'b0;
        ev_x        = cx;
        ev_y        = cy;
        ev_col      = '0;
        lb_we       = 1'b0;
        flush_merge = 1'b0;
        pix_ready   = (state == S_IDLE) || (state == S_RUN);
        case (state)
            S_IDLE, S_RUN: begin
                if (xfer && frame_start) begin
                    ev         = 1'b1;
                    ev_x       = '0;
                    ev_y       = '0;
                    ev_col.bot = pix_in;
                    lb_we      = 1'b1;
                    cx_nxt     = CW'(1);
                    cy_nxt     = '0;
                    state_nxt  = S_RUN;
                end else if (xfer && state == S_RUN) begin
                    ev         = 1'b1;
                    ev_col     = lb_col;
                    ev_col.bot = pix_in;
                    lb_we      = 1'b1;
                    if (cx == X_LAST) begin
                        if (cy == Y_LAST) begin
                            state_nxt = S_FLUSH;
                            cx_nxt    = '0;
                            cy_nxt    = Y_FLUSH;
                        end else begin
                            state_nxt = S_ROWPAD;
                            cx_nxt    = X_PAD;
                        end
                    end else begin
                        cx_nxt = cx + CW'(1);
                    end
                end
            end
            S_ROWPAD: begin
                ev        = 1'b1;
                cx_nxt    = '0;
                cy_nxt    = cy + RW'(1);
                state_nxt = S_RUN;
            end
            S_FLUSH: begin
                ev = 1'b1;
                if (cx == '0) begin
                    // Closes the last row's right edge while loading column 0 of the zero row.
                    flush_merge = 1'b1;
                    ev_x        = X_PAD;
                    ev_y        = Y_LAST;
                    cx_nxt      = CW'(1);
                end else if (cx == X_PAD) begin
                    state_nxt = S_IDLE;
                    cx_nxt    = '0;
                    cy_nxt    = '0;
                end else begin
                    ev_col = lb_col;
                    cx_nxt = cx + CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Prefetch the column the next event will consume so its data is ready on time.
    assign rd_addr = (cx_nxt >= X_PAD) ? '0 : cx_nxt[XW-1:0];

    line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_lb1 (
        .clk     (clk),
        .we      (lb_we),
        .wr_addr (ev_x[XW-1:0]),
        .wr_data (pix_in),
        .rd_addr (rd_addr),
        .rd_data (lb1_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_lb2 (
        .clk     (clk),
        .we      (lb_we),
        .wr_addr (ev_x[XW-1:0]),
        .wr_data (lb1_q),
        .rd_addr (rd_addr),
        .rd_data (lb2_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cx        <= '0;
            cy        <= '0;
            h1        <= '0;
            h2        <= '0;
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
            {p00, p10, p20} <= '0;
            {p01, p11, p21} <= '0;
            {p02, p12, p22} <= '0;
        end else begin
            state     <= state_nxt;
            cx        <= cx_nxt;
            cy        <= cy_nxt;
            win_valid <= out_en;
            if (out_en) begin
                {p00, p10, p20} <= h1;
                {p01, p11, p21} <= h2;
                {p02, p12, p22} <= ev_col;
                win_x <= XW'(ev_x - CW'(1));
                win_y <= YW'(ev_y - RW'(1));
            end
            if (ev) begin
                if (flush_merge) begin
                    h1 <= '0;
                    h2 <= lb_col;
                end else if (ev_x == '0) begin
                    h1 <= '0;
                    h2 <= ev_col;
                end else begin
                    h1 <= h2;
                    h2 <= ev_col;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on a 4x3 image.
module tb_window_3x3_gen;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       reset, pix_valid, frame_start, pix_ready, win_valid;
    logic [3:0] pix_in;
    logic [3:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic [1:0] win_x, win_y;

    always #5 clk = ~clk;

    window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_in      (pix_in),
        .frame_start (frame_start),
        .pix_ready   (pix_ready),
        .p00(p00), .p01(p01), .p02(p02),
        .p10(p10), .p11(p11), .p12(p12),
        .p20(p20), .p21(p21), .p22(p22),
        .win_valid   (win_valid),
        .win_x       (win_x),
        .win_y       (win_y)
    );

    typedef struct packed {
        logic [1:0]  x;
        logic [1:0]  y;
        logic [35:0] w;
    } win_t;

    win_t        exp_q[$];
    logic [3:0]  img  [H][W];
    logic [35:0] seen [H][W];
    logic [35:0] dut_w;
    int          total = 0;
    int          bad   = 0;
    bit          stat_en = 1'b0;
    int          low_tot, low_run, low_max;

    assign dut_w = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

    function automatic void chk(input string name, input logic [35:0] act, input logic [35:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    function automatic logic [3:0] px(input int x, input int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 4'h0;
        return img[y][x];
    endfunction

    function automatic logic [35:0] model_win(input int x, input int y);
        logic [35:0] r = '0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                r = {r[31:0], px(x + dx, y + dy)};
        return r;
    endfunction

    function automatic void push_exp(input int x, input int y);
        win_t e;
        e.x = 2'(x);
        e.y = 2'(y);
        e.w = model_win(x, y);
        exp_q.push_back(e);
    endfunction

    task automatic load_img(input logic [47:0] pat);
        for (int k = 0; k < W * H; k++)
            img[k / W][k % W] = pat[47 - 4 * k -: 4];
    endtask

    task automatic send(input logic [3:0] v, input bit fs);
        bit ok;
        ok          = 1'b0;
        pix_valid   = 1'b1;
        pix_in      = v;
        frame_start = fs;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pix_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: pix_ready stayed %b, required 1", pix_ready);
        end
        @(posedge clk);
        #1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            int x;
            int y;
            x = k % W;
            y = k / W;
            if (gaps) begin
                for (int g = 0; g < 4; g++) begin
                    if ($urandom_range(0, 1) == 0) break;
                    @(posedge clk);
                    #1;
                end
            end
            send(img[y][x], k == 0);
            if (x >= 1 && y >= 1) push_exp(x - 1, y - 1);
            if (x == W - 1 && y >= 1) push_exp(W - 1, y - 1);
            if (k == W * H - 1)
                for (int i = 0; i < W; i++) push_exp(i, H - 1);
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d windows still pending, required 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ready", 36'(pix_ready), 36'd1);
        chk("idle_no_window", 36'(win_valid), 36'd0);
    endtask

    task automatic clear_seen();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                seen[y][x] = '1;
    endtask

    always @(negedge clk) begin
        win_t e;
        if (win_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_window", {win_y, win_x}, 36'h0);
                total++;
                bad++;
                $display("FAIL extra_window: win_valid=1 with no window pending at (%0d,%0d)", win_x, win_y);
            end else begin
                e = exp_q.pop_front();
                chk("win_x", 36'(win_x), 36'(e.x));
                chk("win_y", 36'(win_y), 36'(e.y));
                chk("window", dut_w, e.w);
                if (win_y < 2'(H)) seen[win_y][win_x] = dut_w;
            end
        end
        if (stat_en) begin
            if (!pix_ready) begin
                low_tot++;
                low_run++;
                if (low_run > low_max) low_max = low_run;
            end else begin
                low_run = 0;
            end
        end
    end

    initial begin
        logic [35:0] w;
        bit          all_nz;
        reset       = 1'b1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        pix_in      = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_win_valid", 36'(win_valid), 36'd0);
        chk("rst_window", dut_w, 36'h0);
        chk("rst_coord", {win_y, win_x}, 36'h0);
        chk("rst_ready", 36'(pix_ready), 36'd1);
        @(posedge clk);
        #1;

        // Pixels without frame_start are dropped in IDLE.
        send(4'h9, 1'b0);
        send(4'h3, 1'b0);
        send(4'h7, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_discard", 36'(win_valid), 36'd0);

        // Basic frame 1..12, back-to-back, with pix_ready statistics.
        load_img(48'h123456789ABC);
        clear_seen();
        low_tot = 0; low_run = 0; low_max = 0;
        stat_en = 1'b1;
        feed(W * H, 1'b0);
        wait_done();
        stat_en = 1'b0;
        chk("ready_low_total", 36'(low_tot), 36'd7);
        chk("flush_len", 36'(low_max), 36'd5);
        chk("hand_c00", seen[0][0], 36'h000012056);
        chk("hand_c32", seen[2][3], 36'h780BC0000);
        chk("hand_c11", seen[1][1], 36'h1235679AB);

        // Same frame with random blanking gaps.
        clear_seen();
        low_tot = 0; low_run = 0; low_max = 0;
        stat_en = 1'b1;
        feed(W * H, 1'b1);
        wait_done();
        stat_en = 1'b0;
        chk("gap_ready_low_total", 36'(low_tot), 36'd7);
        chk("gap_hand_c00", seen[0][0], 36'h000012056);

        // Irregular values, including zeros and 0xF.
        load_img(48'h30F7910C5E28);
        feed(W * H, 1'b0);
        wait_done();

        // Abort: new frame_start arrives where pixel (2,1) would be.
        load_img(48'hA1B2C3D4E5F6);
        feed(6, 1'b0);
        load_img(48'h123456789ABC);
        clear_seen();
        feed(W * H, 1'b1);
        wait_done();
        chk("abort_c00", seen[0][0], 36'h000012056);
        chk("abort_c32", seen[2][3], 36'h780BC0000);

        // Reset in the middle of row 1.
        load_img(48'h5A5A5A5A5A5A);
        feed(7, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_win_valid", 36'(win_valid), 36'd0);
        chk("midrst_window", dut_w, 36'h0);
        chk("midrst_coord", {win_y, win_x}, 36'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_ready", 36'(pix_ready), 36'd1);
        load_img(48'h123456789ABC);
        clear_seen();
        feed(W * H, 1'b0);
        wait_done();
        chk("postrst_c00", seen[0][0], 36'h000012056);

        // All-0xF frame; a 3x3 erosion keeps only fully interior centres.
        load_img(48'hFFFFFFFFFFFF);
        clear_seen();
        feed(W * H, 1'b1);
        wait_done();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                w = seen[y][x];
                all_nz = 1'b1;
                for (int n = 0; n < 9; n++)
                    if (w[4 * n +: 4] == 4'h0) all_nz = 1'b0;
                chk($sformatf("erode_%0d_%0d", x, y), all_nz ? 36'hF : 36'h0,
                    (y == 1 && x >= 1 && x <= 2) ? 36'hF : 36'h0);
            end
        end

        chk("queue_empty", 36'(exp_q.size()), 36'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
